// File: rtl/sparse_tok_pkg.sv
// Shared token definitions for the sparse streaming pipeline: widths, special tokens,
// token classifiers and the repsig_gen FSM state type.
package sparse_tok_pkg;

  localparam int TOK_W = 17;

  typedef logic [TOK_W-1:0] tok_t;

  localparam tok_t DONE_TOK = 17'h10100;
  localparam tok_t REPSIG_R = 17'h00001;

  typedef enum logic [1:0] {START, PASS, DONE} repsig_state_t;

  function automatic logic is_ctrl(input tok_t t);
    return t[16];
  endfunction

  function automatic logic is_done(input tok_t t);
    return t == DONE_TOK;
  endfunction

  function automatic logic is_stop(input tok_t t);
    return t[16] & ~t[8];
  endfunction

  // Data tokens collapse to a single repeat; every control token keeps its encoding.
  function automatic tok_t to_repsig(input tok_t t);
    return is_ctrl(t) ? t : REPSIG_R;
  endfunction

endpackage

// File: rtl/reg_fifo.sv
// Register-based FIFO, power-of-two depth, synchronous active-high reset; 1-cycle push-to-pop.
// Built only with REPSIG_GEN_IN_FIFO_EN, the sole configuration that instantiates it.
`ifdef REPSIG_GEN_IN_FIFO_EN
module reg_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
`endif

// File: rtl/repsig_gen.sv
// Turns a coordinate/ref stream into a repsig stream (data -> R, control passes); latency 2 with
// REPSIG_GEN_IN_FIFO_EN (input FIFO) else 1; ready/valid both sides, output held while stalled.
module repsig_gen
  import sparse_tok_pkg::*;
`ifdef REPSIG_GEN_IN_FIFO_EN
#(
  parameter int unsigned FIFO_DEPTH = 2
)
`endif
(
  input  logic             clk,
  input  logic             flush,
  input  logic             clk_en,
  input  logic             tile_en,
  input  logic [TOK_W-1:0] base_data_in,
  input  logic             base_data_in_valid,
  output logic             base_data_in_ready,
  output logic [TOK_W-1:0] repsig_data_out,
  output logic             repsig_data_out_valid,
  input  logic             repsig_data_out_ready,
  output logic             tile_done
);

  repsig_state_t state, state_nxt;
  tok_t          out_dat;
  tok_t          src_dat;
  logic          out_vld;
  logic          done_pend;
  logic          rst;
  logic          run;
  logic          out_hs;
  logic          out_free;
  logic          push;
  logic          pop;

  // A disabled tile sits in its reset state, so it resumes cleanly at a tile boundary.
  assign rst      = flush | ~tile_en;
  assign run      = clk_en & tile_en & ~flush;

  assign repsig_data_out       = out_dat;
  assign repsig_data_out_valid = out_vld & run;
  assign out_hs                = repsig_data_out_valid & repsig_data_out_ready;
  assign out_free              = ~out_vld | repsig_data_out_ready;
  assign tile_done             = out_hs & (state == DONE);

`ifdef REPSIG_GEN_IN_FIFO_EN
  logic fifo_full;
  logic fifo_empty;

  // done_pend stops the next tile entering the FIFO behind a done still queued.
  assign base_data_in_ready = run & ~fifo_full & (state != DONE) & ~done_pend;
  assign push               = base_data_in_valid & base_data_in_ready;
  assign pop                = run & ~fifo_empty & out_free & (state != DONE);

  reg_fifo #(
    .W     (TOK_W),
    .DEPTH (FIFO_DEPTH)
  ) u_in_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (base_data_in),
    .pop      (pop),
    .pop_dat  (src_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );
`else
  assign base_data_in_ready = run & out_free & (state != DONE) & ~done_pend;
  assign push               = base_data_in_valid & base_data_in_ready;
  assign pop                = push;
  assign src_dat            = base_data_in;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      START, PASS: if (pop) state_nxt = is_done(src_dat) ? DONE : PASS;
      DONE:        if (out_hs) state_nxt = START;
      default:     state_nxt = START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= START;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_dat <= '0;
    end else if (pop) begin
      out_vld <= 1'b1;
      out_dat <= to_repsig(src_dat);
    end else if (out_hs) begin
      out_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                done_pend <= 1'b0;
    else if (push && is_done(base_data_in)) done_pend <= 1'b1;
    else if (tile_done)                     done_pend <= 1'b0;
  end

endmodule

// File: tb/tb_repsig_gen.sv
// Directed bench for repsig_gen: table of {input token, expected repsig, expected tile_done}
// streamed with scoreboard checks, plus hand-written stall, clk_en, flush and tile_en sequences.
module tb_repsig_gen;

`ifdef REPSIG_GEN_IN_FIFO_EN
  localparam int LAT    = 2;
  localparam int BP_ACC = 3;
  localparam int FL_ACC = 2;
`else
  localparam int LAT    = 1;
  localparam int BP_ACC = 1;
  localparam int FL_ACC = 1;
`endif

  typedef struct {
    logic [16:0] in_tok;
    logic [16:0] exp_tok;
    logic        exp_done;
  } vec_t;

  logic        clk = 1'b0;
  logic        flush;
  logic        clk_en;
  logic        tile_en;
  logic [16:0] in_dat;
  logic        in_vld;
  logic        in_rdy;
  logic [16:0] out_dat;
  logic        out_vld;
  logic        out_rdy;
  logic        tile_done;

  int   checks   = 0;
  int   failures = 0;
  vec_t vec [29];

  always #5 clk = ~clk;

  repsig_gen dut (
    .clk                   (clk),
    .flush                 (flush),
    .clk_en                (clk_en),
    .tile_en               (tile_en),
    .base_data_in          (in_dat),
    .base_data_in_valid    (in_vld),
    .base_data_in_ready    (in_rdy),
    .repsig_data_out       (out_dat),
    .repsig_data_out_valid (out_vld),
    .repsig_data_out_ready (out_rdy),
    .tile_done             (tile_done)
  );

  task automatic chk(input string name, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_stream(input int first, input int n, input int stall,
                            input int ce_at, input int ce_len,
                            output int acc_stall, output int lat, output int span);
    int ip, op, t, t_acc0, t_vld0, t_out0, t_out3;
    bit pv, pend;
    logic [16:0] pd;
    ip = 0; op = 0; t = 0; pv = 0; pend = 0; pd = '0; acc_stall = 0;
    t_acc0 = -1; t_vld0 = -1; t_out0 = 0; t_out3 = 0;
    while (op < n && t < 300) begin
      in_vld  = (ip < n);
      in_dat  = (ip < n) ? vec[first+ip].in_tok : 17'h0;
      out_rdy = (t >= stall);
      clk_en  = !(t >= ce_at && t < ce_at + ce_len);
      #1;
      if (!clk_en) begin
        chk("clk_en_gate", {15'b0, in_rdy, out_vld}, 17'h0);
      end else begin
        if (pv) begin
          chk("stall_vld", 17'(out_vld), 17'd1);
          chk("stall_dat", out_dat, pd);
        end
        if (out_vld && t_vld0 < 0) t_vld0 = t;
        if (out_vld && out_rdy) begin
          chk("out_tok", out_dat, vec[first+op].exp_tok);
          chk("tile_done", 17'(tile_done), 17'(vec[first+op].exp_done));
          if (op == 0) t_out0 = t;
          if (op == 3) t_out3 = t;
          if (vec[first+op].exp_done) pend = 0;
          op++;
        end else begin
          chk("tile_done_idle", 17'(tile_done), 17'd0);
        end
        pv = out_vld && !out_rdy;
        pd = out_dat;
        if (in_vld && in_rdy) begin
          chk("no_merge", 17'(pend), 17'd0);
          if (in_dat == 17'h10100) pend = 1;
          if (t_acc0 < 0) t_acc0 = t;
          if (t < stall) acc_stall++;
          ip++;
        end
      end
      @(posedge clk); #1;
      t++;
    end
    chk("stream_count", 17'(op), 17'(n));
    in_vld = 1'b0;
    clk_en = 1'b1;
    #1;
    chk("rdy_after_done", 17'(in_rdy), 17'd1);
    lat  = t_vld0 - t_acc0;
    span = t_out3 - t_out0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int acc, lat, span, fl_acc;

    // basic tile, then stop/other-control/data variety
    vec[0]  = '{17'h00003, 17'h00001, 1'b0};
    vec[1]  = '{17'h00007, 17'h00001, 1'b0};
    vec[2]  = '{17'h10000, 17'h10000, 1'b0};
    vec[3]  = '{17'h10100, 17'h10100, 1'b1};
    vec[4]  = '{17'h0FFFF, 17'h00001, 1'b0};
    vec[5]  = '{17'h10003, 17'h10003, 1'b0};
    vec[6]  = '{17'h1FFFF, 17'h1FFFF, 1'b0};
    vec[7]  = '{17'h10105, 17'h10105, 1'b0};
    vec[8]  = '{17'h00000, 17'h00001, 1'b0};
    vec[9]  = '{17'h10100, 17'h10100, 1'b1};
    // back-to-back tiles
    vec[10] = '{17'h00001, 17'h00001, 1'b0};
    vec[11] = '{17'h10100, 17'h10100, 1'b1};
    vec[12] = '{17'h00002, 17'h00001, 1'b0};
    vec[13] = '{17'h10100, 17'h10100, 1'b1};
    // backpressure
    vec[14] = '{17'h00011, 17'h00001, 1'b0};
    vec[15] = '{17'h00022, 17'h00001, 1'b0};
    vec[16] = '{17'h00033, 17'h00001, 1'b0};
    vec[17] = '{17'h00044, 17'h00001, 1'b0};
    vec[18] = '{17'h00055, 17'h00001, 1'b0};
    vec[19] = '{17'h10100, 17'h10100, 1'b1};
    // clk_en pause mid-stream
    vec[20] = '{17'h00006, 17'h00001, 1'b0};
    vec[21] = '{17'h10001, 17'h10001, 1'b0};
    vec[22] = '{17'h00008, 17'h00001, 1'b0};
    vec[23] = '{17'h10002, 17'h10002, 1'b0};
    vec[24] = '{17'h0000C, 17'h00001, 1'b0};
    vec[25] = '{17'h10100, 17'h10100, 1'b1};
    // fresh tile after flush, then empty tensor
    vec[26] = '{17'h00005, 17'h00001, 1'b0};
    vec[27] = '{17'h10100, 17'h10100, 1'b1};
    vec[28] = '{17'h10100, 17'h10100, 1'b1};

    flush = 1'b1; clk_en = 1'b1; tile_en = 1'b1;
    in_vld = 1'b0; in_dat = '0; out_rdy = 1'b0;
    @(posedge clk); #1;
    chk("rdy_during_flush", 17'(in_rdy), 17'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    chk("rst_vld", 17'(out_vld), 17'd0);
    chk("rst_dat", out_dat, 17'h0);
    chk("rst_tile_done", 17'(tile_done), 17'd0);
    chk("rst_rdy", 17'(in_rdy), 17'd1);

    run_stream(0, 4, 0, 1000, 0, acc, lat, span);
    chk("latency", 17'(lat), 17'(LAT));
    chk("throughput_span", 17'(span), 17'd3);

    run_stream(4, 6, 0, 1000, 0, acc, lat, span);
    run_stream(10, 4, 0, 1000, 0, acc, lat, span);

    run_stream(14, 6, 6, 1000, 0, acc, lat, span);
    chk("bp_accepts", 17'(acc), 17'(BP_ACC));

    run_stream(20, 6, 0, 3, 3, acc, lat, span);

    // flush with tokens (including a done) buffered
    out_rdy = 1'b0;
    fl_acc  = 0;
    for (int c = 0; c < 6; c++) begin
      in_vld = (fl_acc < 2);
      in_dat = (fl_acc == 0) ? 17'h00009 : 17'h10100;
      #1;
      if (in_vld && in_rdy) fl_acc++;
      @(posedge clk); #1;
    end
    chk("flush_buffered", 17'(fl_acc), 17'(FL_ACC));
    in_vld = 1'b0; out_rdy = 1'b1; flush = 1'b1;
    #1;
    chk("flush_cycle", {14'b0, in_rdy, out_vld, tile_done}, 17'h0);
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    chk("flush_vld", 17'(out_vld), 17'd0);
    chk("flush_rdy", 17'(in_rdy), 17'd1);
    chk("flush_dat", out_dat, 17'h0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("flush_idle", {15'b0, out_vld, tile_done}, 17'h0);
    end
    run_stream(26, 2, 0, 1000, 0, acc, lat, span);

    // tile disabled: offered tokens must be ignored
    tile_en = 1'b0; in_vld = 1'b1; in_dat = 17'h00003; out_rdy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("tile_en_off", {14'b0, in_rdy, out_vld, tile_done}, 17'h0);
      @(posedge clk); #1;
    end
    tile_en = 1'b1; in_vld = 1'b0;
    @(posedge clk); #1;

    run_stream(28, 1, 0, 1000, 0, acc, lat, span);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/repsig_gen.md
# repsig_gen

Repeat-signal generator for the sparse streaming pipeline. Consumes a coordinate/reference stream from an upstream scanner and emits the repeat-signal (repsig) stream that directly feeds a Repeat stage's `repsig_data_in`. Each data token becomes one repeat token; stop and done tokens pass through with their hierarchy intact. Both ports use the standard 17-bit ready/valid token interface.

## Interface
- `TOK_W`, 17, token width; bit 16 set means control token.
- `FIFO_DEPTH`, 2, input FIFO entries; power of two, ≥2.
- `clk`  in  1  sole clock; everything on rising edge.
- `flush`  in  1  reset: one clock; reset is synchronous and active-high.
- `clk_en`  in  1  low: all state holds; `base_data_in_ready` and `repsig_data_out_valid` forced 0.
- `tile_en`  in  1  low: block inert (ready/valid outputs 0), state held in reset values.
- `base_data_in`  in  17  upstream coordinate/ref token.
- `base_data_in_valid`  in  1  upstream valid.
- `base_data_in_ready`  out  1  accept; handshake = valid & ready.
- `repsig_data_out`  out  17  repsig token to the Repeat stage.
- `repsig_data_out_valid`  out  1  output valid.
- `repsig_data_out_ready`  in  1  downstream accept.
- `tile_done`  out  1  one-cycle pulse on the cycle the done token handshakes out.

## Operation
- Token classes: data (bit16=0); stop (bit16=1, bit8=0, level in [7:0]); done = 17'h10100.
- Mapping: data of any value -> 17'h00001 (R); stop -> forwarded unchanged; done -> forwarded unchanged; any other control token -> forwarded unchanged.
- Path: input FIFO -> translate -> output register. The FIFO pops when the output register is empty or handshaking this cycle.
- FSM `START` / `PASS` / `DONE`, reset `START`:
  - `START` -> `PASS` on popping a non-done token.
  - `START` or `PASS` -> `DONE` when the done token is popped into the output register.
  - `DONE`: input ready 0 and no pops. On the done output handshake, pulse `tile_done` and go to `START`.
- Empty tensor (done as first token): 17'h10100 out, `tile_done` pulses, FSM back to `START`.
- Tokens after done in the same beat: not accepted until `START`. Never merged across tiles.

## Timing
- Reset values: `repsig_data_out`=0, `repsig_data_out_valid`=0, `tile_done`=0, FIFO empty, FSM `START`.
- `base_data_in_ready` = tile_en & clk_en & !flush & FIFO not full & state≠`DONE`. Combinational from state only, never from `base_data_in_valid`.
- Latency (macro defined): input handshake at cycle N -> output valid at N+2 when unstalled.
- Throughput: 1 token/cycle sustained with `repsig_data_out_ready`=1.
- Output holds data and valid stable while valid & !ready.
- Simultaneous FIFO push and pop when full is not allowed: ready is already 0.
- Simultaneous push and pop when not full: occupancy unchanged.
- `flush` mid-stream: the next cycle shows reset values. Buffered tokens are discarded; any in-flight done gives no `tile_done`.
- `flush` overrides `clk_en` and `tile_en`.

## Configuration
- `REPSIG_GEN_IN_FIFO_EN` defined: `FIFO_DEPTH`-entry input FIFO as above; latency 2.
- Not defined: the FIFO is replaced by direct translation into the output register.
  - `base_data_in_ready` = output register empty | `repsig_data_out_ready` (same gating otherwise).
  - Latency 1. `FIFO_DEPTH` is ignored.

## Structure
- Package `sparse_tok_pkg`:
  - `TOK_W`, `DONE_TOK`=17'h10100, `REPSIG_R`=17'h00001.
  - Functions `is_ctrl`, `is_done`, `is_stop`.
  - `repsig_state_t` enum.
- Sub-module `reg_fifo` (parameterised width/depth, synchronous active-high reset, push/pop/full/empty), instantiated only under `REPSIG_GEN_IN_FIFO_EN`.

## Test plan
- Basic: inputs 0x00003, 0x00007, 0x10000, 0x10100 with out_ready=1 -> outputs 0x00001, 0x00001, 0x10000, 0x10100 on consecutive cycles; `tile_done` high only on the 0x10100 handshake.
- Backpressure: out_ready=0 for 6 cycles while feeding 5 data tokens -> ready drops after FIFO_DEPTH+1 (3) accepts. Releasing gives five 0x00001 outputs, none lost or duplicated, and valid/data stable while stalled.
- Empty tensor: single 0x10100 -> single 0x10100 out, one `tile_done` pulse, then ready=1 in `START`.
- Back-to-back tiles:
  - Tile A (0x00001, 0x10100) followed immediately by tile B (0x00002, 0x10100).
  - B's first token is not accepted before A's done handshake.
  - Output is 0x00001, 0x10100, 0x00001, 0x10100 with two `tile_done` pulses.
- Flush mid-stream: 2 tokens buffered, flush for 1 cycle -> next cycle valid=0, ready=1, `tile_done` never pulses, and a fresh 0x00005, 0x10100 yields 0x00001, 0x10100.
- clk_en/tile_en: deassert clk_en for 3 cycles mid-stream -> ready=valid=0, FIFO contents and output preserved and resumed in order. With tile_en=0 throughout, no handshakes occur.
